// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small decode helpers used by the controller.
package mdu_ctrl_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_signed(input mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Bundle between the EX stage and the multiply/divide unit, with the FSM
// state exposed for observation.
interface mdu_ctrl_if
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
);
  // start is taken only on an edge where busy=0 and cancel=0; busy rises the
  // next cycle and stays high until the edge that writes hi/lo and pulses done.
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  mdu_state_e       state;

  modport master (
    output start, op, a, b, cancel, mthi, mtlo, wdata,
    input  hi, lo, busy, done, state
  );

  modport slave (
    input  start, op, a, b, cancel, mthi, mtlo, wdata,
    output hi, lo, busy, done, state
  );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the unsigned datapath: shift-add for multiply, restoring
// shift-subtract for divide, operating on the {acc, mq} register pair.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_bits;

  always_comb begin
    sum         = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
    shifted     = {acc, mq[WIDTH-1]};
    diff        = {1'b0, shifted} - {2'b00, operand};
    // The partial remainder stays below the divisor, so bit WIDTH of a
    // non-negative difference is always zero.
    unused_bits = diff[WIDTH];
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        acc_nxt = diff[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      mq_nxt  = {sum[0], mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer with HI/LO registers for the MIPS EX stage.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rstn,
  mdu_ctrl_if.slave  bus
);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mq_nxt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  logic               a_neg;
  logic               b_neg;
  logic               start_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operands are reduced to magnitudes up front; signs are reapplied in FIX.
  always_comb begin
    a_neg     = op_is_signed(mdu_op_e'(bus.op)) & bus.a[WIDTH-1];
    b_neg     = op_is_signed(mdu_op_e'(bus.op)) & bus.b[WIDTH-1];
    start_div = op_is_div(mdu_op_e'(bus.op));
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    prod_fix  = neg_q ? -{acc, mq} : {acc, mq};
    quo_fix   = div0 ? '1 : (neg_q ? -mq : mq);
    rem_fix   = neg_r ? -acc : acc;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .mq      (mq),
    .operand (operand),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      operand <= '0;
      acc     <= '0;
      mq      <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mthi) hi <= bus.wdata;
          if (bus.mtlo) lo <= bus.wdata;
          if (bus.start && !bus.cancel) begin
            is_div  <= start_div;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= start_div & a_neg;
            div0    <= start_div && (bus.b == '0);
            busy    <= 1'b1;
            cnt     <= CNT_W'(WIDTH - 1);
            acc     <= '0;
            // Divide shifts the dividend out of mq; multiply shifts the multiplier.
            operand <= start_div ? b_mag : a_mag;
            mq      <= start_div ? a_mag : b_mag;
            state   <= CALC;
`ifdef MDU_FAST_MUL_EN
            if (!start_div) begin
              {acc, mq} <= fast_prod;
              state     <= FIX;
            end
`endif
          end
        end
        CALC: begin
          if (bus.cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_nxt;
            mq  <= mq_nxt;
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        FIX: begin
          // A flush arriving now belongs to a younger instruction, so commit anyway.
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.hi    = hi;
  assign bus.lo    = lo;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.state = state;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl against an arithmetic reference
// of the MIPS HI/LO results and the start-to-done timing.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;
  logic [63:0] exp_q[$];

  mdu_ctrl_if #(.WIDTH(W)) bus ();

  mdu_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} from MIPS arithmetic rules.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return ux * uy;
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          return {r[31:0], q[31:0]};
        end
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Negedges from start to the one where done is visible.
  function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
    return o[1] ? W + 2 : 2;
`else
    return (o == 2'b00 || o == 2'b11 || o[1] || !o[1]) ? W + 2 : W + 2;
`endif
  endfunction

  // mode 0: plain; 1: mthi issued together with start; 2: mthi pulsed mid-operation
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int mode);
    int          cyc;
    int          busy_cyc;
    logic [31:0] hi_before;
    logic [63:0] e;
    hi_before = bus.hi;
    exp_q.push_back(ref_model(o, x, y));
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    if (mode == 1) begin
      bus.mthi  = 1'b1;
      bus.wdata = 32'hCAFE_0001;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    if (mode == 1) check("mthi_with_start", bus.hi, 32'hCAFE_0001);
    cyc      = 1;
    busy_cyc = 0;
    while (!bus.done && cyc < 200) begin
      if (bus.busy) busy_cyc++;
      if (mode == 2 && cyc == 5) begin
        bus.mthi  = 1'b1;
        bus.wdata = 32'h0000_1234;
      end
      if (mode == 2 && cyc == 6) begin
        bus.mthi = 1'b0;
        check("mthi_busy_ignored", bus.hi, hi_before);
      end
      @(negedge clk);
      cyc++;
    end
    check("op_latency", cyc, exp_lat(o));
    check("busy_cycles", busy_cyc, exp_lat(o) - 1);
    check("busy_in_done", bus.busy, 1'b0);
    e = exp_q.pop_front();
    check("result_hilo", {bus.hi, bus.lo}, e);
  endtask

  task automatic done_drops();
    @(negedge clk);
    check("done_one_cycle", bus.done, 1'b0);
  endtask

  initial begin
    logic [31:0] edge_v[4];
    logic [31:0] x, y;
    logic [1:0]  o;
    int          done_seen;
    edge_v[0] = 32'h8000_0000;
    edge_v[1] = 32'hFFFF_FFFF;
    edge_v[2] = 32'h0000_0001;
    edge_v[3] = 32'h7FFF_FFFF;
    n_checks  = 0;
    n_errors  = 0;
    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.cancel = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_state", bus.state, IDLE);
    rstn = 1'b1;
    @(negedge clk);

    // directed arithmetic cases
    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); done_drops();
    do_op(MDU_MULT, -32'sd3, 32'd7, 1);                done_drops();
    do_op(MDU_DIV, -32'sd7, 32'd2, 0);                 done_drops();
    do_op(MDU_DIVU, 32'd7, 32'd2, 0);                  done_drops();
    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);   done_drops();
    do_op(MDU_DIVU, 32'd5, 32'd0, 0);                  done_drops();
    do_op(MDU_DIV, -32'sd5, 32'd0, 0);                 done_drops();

    // mthi while busy is dropped; mtlo in the done cycle lands
    do_op(MDU_DIV, 32'd1000, 32'd7, 2);
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000_ABCD;
    @(negedge clk);
    bus.mtlo = 1'b0;
    check("mtlo_after_done", bus.lo, 32'h0000_ABCD);
    check("done_one_cycle", bus.done, 1'b0);

    // back-to-back: second start issued in the done cycle
    do_op(MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    do_op(MDU_DIV, 32'hDEAD_BEEF, 32'h0000_0013, 0);
    done_drops();

    // mthi + mtlo together
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h5A5A_1111;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check("mthi_mtlo_hi", bus.hi, 32'h5A5A_1111);
    check("mthi_mtlo_lo", bus.lo, 32'h5A5A_1111);

    // cancel beats start in IDLE
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = MDU_DIV;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("cancel_over_start", bus.busy, 1'b0);

    // cancel mid-divide
    bus.start = 1'b1;
    bus.op    = MDU_DIV;
    bus.a     = 32'd99;
    bus.b     = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", bus.busy, 1'b0);
    check("cancel_state", bus.state, IDLE);
    check("cancel_hi", bus.hi, 32'h5A5A_1111);
    check("cancel_lo", bus.lo, 32'h5A5A_1111);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    check("cancel_no_done", done_seen, 0);

    // randomized operations
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 20));
      do_op(o, x, y, 0);
      if ($urandom_range(0, 1) == 0) done_drops();
    end
    done_drops();

    // asynchronous reset in the middle of CALC
    bus.start = 1'b1;
    bus.op    = MDU_MULTU;
    bus.a     = 32'hFFFF_0000;
    bus.b     = 32'h0000_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("async_rst_hi", bus.hi, 32'd0);
    check("async_rst_lo", bus.lo, 32'd0);
    check("async_rst_busy", bus.busy, 1'b0);
    check("async_rst_done", bus.done, 1'b0);
    check("async_rst_state", bus.state, IDLE);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_op(MDU_MULT, 32'h8000_0000, 32'h8000_0000, 0);
    done_drops();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Iterative multiply/divide unit with its sequencer and HI/LO architectural registers for the pipelined MIPS core.
- Sits beside the single-cycle ALU in EX and handles MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO sources.
- Drives `busy` to the hazard unit so the pipeline stalls on a dependent HI/LO access.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be even.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  launch operation; sampled only when busy=0
- op  in  2  operation code (see package)
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- cancel  in  1  pipeline flush; aborts an in-flight operation
- mthi  in  1  write `wdata` to HI
- mtlo  in  1  write `wdata` to LO
- wdata  in  WIDTH  MTHI/MTLO data
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; HI/LO were just updated by an operation

Behaviour:
- Reset (rstn=0, asynchronous): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- States:
  - IDLE: start=1 and cancel=0 → latch operand magnitudes and op.
    - MULT/MULTU → CALC, or FIX when MDU_FAST_MUL_EN is defined.
    - DIV/DIVU → CALC.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter runs WIDTH-1 down to 0; at 0 → FIX.
  - FIX: apply sign correction, write HI/LO, pulse done, → IDLE.
- busy=1 in CALC and FIX. busy is registered: it rises the cycle after the start edge.
- Latency (start edge = E0):
  - Iterative: HI/LO written at E(WIDTH+1); done=1 during the following cycle, busy=0 in that cycle.
  - A new start is accepted in the done cycle.
- start while busy=1: ignored; no queuing.
- Signed ops (MULT, DIV):
  - Operate on magnitudes.
  - Product/quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero: full latency; hi=a, lo=all ones, for both DIV and DIVU.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - When busy=0: hi/lo take wdata at the edge, simultaneous with start allowed. The later operation result overwrites.
  - When busy=1: ignored.
  - mthi and mtlo together: both written.
- cancel:
  - When busy=1: → IDLE next edge, hi/lo unchanged, no done.
  - cancel has priority over start in the same cycle.
  - cancel in IDLE or FIX-final edge: FIX still commits. A flush of an instruction past EX must not cancel.
- No output depends combinationally on inputs.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle combinational 2*WIDTH multiplier.
  - IDLE → FIX directly; HI/LO written at E1; busy high for exactly one cycle.
  - Division is unchanged.
- Undefined: multiply is iterative with the same latency as divide.

Decomposition:
- Shared encode-def header holds:
  - op codes: MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11.
  - State encodings: IDLE/CALC/FIX.
- One natural sub-module, `mdu_step`: combinational single-iteration datapath (add-or-pass for multiply, trial subtract for divide). mdu_ctrl keeps the FSM, counter, sign fix-up and HI/LO.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after WIDTH+1 edges hi=0xFFFFFFFE lo=0x00000001; done one cycle; busy 33 cycles.
- MULT a=-3 b=7 → hi=0xFFFFFFFF lo=0xFFFFFFEB; with MDU_FAST_MUL_EN the same result at E1.
- DIV sign cases:
  - a=-7 b=2 → lo=0xFFFFFFFD hi=0xFFFFFFFF.
  - DIVU a=7 b=2 → lo=3 hi=1.
  - DIV 0x80000000 / -1 → lo=0x80000000 hi=0.
- DIVU a=5 b=0 → hi=5 lo=0xFFFFFFFF after full latency.
- Start DIV, assert cancel at cycle 10 → busy=0 next cycle, hi/lo keep prior values, no done. Back-to-back start in the done cycle is accepted.
- mthi wdata=0x1234 while busy → ignored. After done, mtlo 0xABCD → lo=0xABCD next edge. Assert rstn=0 mid-CALC → all outputs 0 immediately.
